// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter:
// access-type codes, FSM state encoding and port identifiers.
package mem_port_arbiter_pkg;

    // Width of the access-type code shared with the external memory interface.
    localparam int EXT_MEM_CWIDTH = 3;

    localparam logic [EXT_MEM_CWIDTH-1:0] TYPE_WORD   = 3'd0;
    localparam logic [EXT_MEM_CWIDTH-1:0] TYPE_HALF_U = 3'd1;
    localparam logic [EXT_MEM_CWIDTH-1:0] TYPE_HALF_S = 3'd2;
    localparam logic [EXT_MEM_CWIDTH-1:0] TYPE_BYTE_U = 3'd3;
    localparam logic [EXT_MEM_CWIDTH-1:0] TYPE_BYTE_S = 3'd4;
    // Codes 5..7 are not listed: every consumer treats them as WORD.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RMW_RD  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Half-word and byte accesses cover only part of a RAM word.
    function automatic logic is_sub_word(input logic [EXT_MEM_CWIDTH-1:0] acc_type);
        return (acc_type == TYPE_HALF_U) || (acc_type == TYPE_HALF_S) ||
               (acc_type == TYPE_BYTE_U) || (acc_type == TYPE_BYTE_S);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane unit: extracts and extends a load lane from a RAM
// word, merges store bytes into a RAM word, and flags misaligned accesses.
module mem_lane_unit
    import mem_port_arbiter_pkg::*;
(
    input  logic [31:0]               word,
    input  logic [1:0]                pos,
    input  logic [EXT_MEM_CWIDTH-1:0] acc_type,
    input  logic [31:0]               store_data,
    output logic [31:0]               load_val,
    output logic [31:0]               merged_word,
    output logic                      misaligned
);

    logic        is_half;
    logic        is_byte;
    logic        is_signed;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign is_half   = (acc_type == TYPE_HALF_U) || (acc_type == TYPE_HALF_S);
    assign is_byte   = (acc_type == TYPE_BYTE_U) || (acc_type == TYPE_BYTE_S);
    assign is_signed = (acc_type == TYPE_HALF_S) || (acc_type == TYPE_BYTE_S);

    assign byte_lane = word[{pos, 3'b000} +: 8];
    assign half_lane = pos[1] ? word[31:16] : word[15:0];

    // Halves must sit on even bytes, words on word boundaries; bytes always fit.
    assign misaligned = is_half ? pos[0] : (is_byte ? 1'b0 : (pos != 2'b00));

    // Load extraction: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        load_val = word;
        if (is_byte) begin
            load_val = is_signed ? {{24{byte_lane[7]}}, byte_lane} : {24'd0, byte_lane};
        end else if (is_half) begin
            load_val = is_signed ? {{16{half_lane[15]}}, half_lane} : {16'd0, half_lane};
        end
    end

    // Store merge: each byte lane takes new data when the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_en;
            logic [7:0] lane_data;

            assign lane_en   = is_byte ? (pos == 2'(gi)) :
                               is_half ? (pos[1] == 1'(gi / 2)) : 1'b1;
            assign lane_data = is_byte ? store_data[7:0] :
                               is_half ? store_data[8*(gi%2) +: 8] : store_data[8*gi +: 8];
            assign merged_word[8*gi +: 8] = lane_en ? lane_data : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between an
// instruction-fetch port (I) and a load/store port (D). Sub-word stores run
// as read-modify-write; misaligned accesses get an error response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int TYPE_W = EXT_MEM_CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic              i_err,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [TYPE_W-1:0] d_type,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              ram_r_ena,
    output logic              ram_w_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    arb_state_t                state_reg, state_next;
    logic                      last_grant_reg;
    logic                      txn_port_reg;
    logic                      txn_err_reg;
    logic [EXT_MEM_CWIDTH-1:0] txn_type_reg;
    logic [1:0]                txn_pos_reg;
    logic [31:0]               txn_wdata_reg;
    logic [ADDR_W-1:0]         addr_reg;
    logic [31:0]               i_rdata_reg;
    logic [31:0]               d_rdata_reg;

    logic                      grant_any;
    logic                      grant_port;
    logic                      sel_we;
    logic [EXT_MEM_CWIDTH-1:0] sel_type;
    logic [31:0]               sel_addr;
    logic [31:0]               sel_wdata;
    logic [EXT_MEM_CWIDTH-1:0] lane_type;
    logic [1:0]                lane_pos;
    logic [31:0]               lane_load;
    logic [31:0]               lane_merged;
    logic                      lane_misaligned;
    logic                      unused_addr_bits;

    // Pick the winner (alternating on contention) and mux its request fields.
    always_comb begin
        grant_any = rst && (state_reg == ST_IDLE) && (i_req || d_req);
        if (i_req && d_req) begin
            grant_port = ~last_grant_reg;
        end else if (i_req) begin
            grant_port = PORT_I;
        end else begin
            grant_port = PORT_D;
        end
        if (grant_port == PORT_D) begin
            sel_we    = d_we;
            sel_type  = d_type;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end else begin
            sel_we    = 1'b0;
            sel_type  = TYPE_WORD;
            sel_addr  = i_addr;
            sel_wdata = 32'd0;
        end
    end

    // Byte-within-word and bits above the RAM range do not address the RAM.
    assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

    // One lane unit serves the alignment check at grant and the later data steps.
    assign lane_type = (state_reg == ST_IDLE) ? sel_type : txn_type_reg;
    assign lane_pos  = (state_reg == ST_IDLE) ? sel_addr[1:0] : txn_pos_reg;

    mem_lane_unit u_lane (
        .word        (ram_rdata),
        .pos         (lane_pos),
        .acc_type    (lane_type),
        .store_data  (txn_wdata_reg),
        .load_val    (lane_load),
        .merged_word (lane_merged),
        .misaligned  (lane_misaligned)
    );

    // Next-state and RAM/grant strobes; enables come straight from state so reset drops them.
    always_comb begin
        state_next = state_reg;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        ram_r_ena  = 1'b0;
        ram_w_ena  = 1'b0;
        ram_wdata  = 32'd0;
        ram_addr   = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    i_gnt    = (grant_port == PORT_I);
                    d_gnt    = (grant_port == PORT_D);
                    ram_addr = sel_addr[ADDR_W+1:2];
                    if (lane_misaligned) begin
                        state_next = ST_RESP;
                    end else if (!sel_we) begin
                        ram_r_ena  = 1'b1;
                        state_next = ST_RD_WAIT;
                    end else if (is_sub_word(sel_type)) begin
                        ram_r_ena  = 1'b1;
                        state_next = ST_RMW_RD;
                    end else begin
                        ram_w_ena  = 1'b1;
                        ram_wdata  = sel_wdata;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RD_WAIT: state_next = ST_RESP;
            ST_RMW_RD: begin
                ram_w_ena  = 1'b1;
                ram_wdata  = lane_merged;
                state_next = ST_RESP;
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, transaction capture at grant and load-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= PORT_D;
            txn_port_reg   <= PORT_I;
            txn_err_reg    <= 1'b0;
            txn_type_reg   <= TYPE_WORD;
            txn_pos_reg    <= 2'd0;
            txn_wdata_reg  <= 32'd0;
            addr_reg       <= '0;
            i_rdata_reg    <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (grant_any) begin
                last_grant_reg <= grant_port;
                txn_port_reg   <= grant_port;
                txn_err_reg    <= lane_misaligned;
                txn_type_reg   <= sel_type;
                txn_pos_reg    <= sel_addr[1:0];
                txn_wdata_reg  <= sel_wdata;
                addr_reg       <= sel_addr[ADDR_W+1:2];
            end
            if (state_reg == ST_RD_WAIT) begin
                if (txn_port_reg == PORT_I) begin
                    i_rdata_reg <= lane_load;
                end else begin
                    d_rdata_reg <= lane_load;
                end
            end
        end
    end

    assign i_valid = (state_reg == ST_RESP) && (txn_port_reg == PORT_I);
    assign d_valid = (state_reg == ST_RESP) && (txn_port_reg == PORT_D);
    assign i_err   = i_valid && txn_err_reg;
    assign d_err   = d_valid && txn_err_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the CPU and the single-port data RAM (RAM / IP_RAM); shares that RAM between an instruction-fetch port (port I) and a load/store port (port D).
- Arbitrates round-robin and does the sub-word alignment and sign/zero extension internally.
- Sequences sub-word stores as a two-cycle read-modify-write.
- Rejects misaligned accesses with an error response instead of touching the RAM.

Parameters:
- ADDR_W, 11, RAM word-address width; ram_addr = byte address [ADDR_W+1:2].
- TYPE_W, 3, access-type code width (equals shared EXT_MEM_CWIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle (combinational, IDLE only).
- i_valid  out  1  one-cycle fetch response pulse.
- i_err  out  1  misaligned fetch; qualifies i_valid.
- i_rdata  out  32  fetched word; holds until the next i_valid.
- d_req  in  1  data request; held with its fields until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_type  in  TYPE_W  access type code.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data; sub-word stores use the low bits.
- d_gnt  out  1  data request accepted.
- d_valid  out  1  one-cycle data response pulse (loads and stores).
- d_err  out  1  misaligned access; qualifies d_valid.
- d_rdata  out  32  extended load data.
- ram_r_ena  out  1  RAM read enable.
- ram_w_ena  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM read word; valid the cycle after ram_r_ena.

Behaviour:
- Reset values:
  - state = IDLE.
  - all gnt/valid/err/ena outputs 0.
  - rdata registers and ram_addr/ram_wdata = 0.
  - last_grant = D, so port I wins the first tie.
- Type codes: 0 WORD, 1 HALF_U, 2 HALF_S, 3 BYTE_U, 4 BYTE_S; codes 5-7 are treated as WORD.
- Byte lane: byte n of a word occupies bits [8n+7:8n]; half at addr[1]=1 occupies [31:16].
- Port I is always a WORD load.
- Alignment:
  - Misaligned = WORD with addr[1:0] != 0, or HALF with addr[0] = 1.
  - Misaligned access: granted, no RAM enable, state RESP, err=1 with valid at T+1. rdata is unchanged.
- Arbitration (IDLE only):
  - Single requester: that requester is granted.
  - Both requesting: grant the port not equal to last_grant.
  - last_grant updates on every grant.
  - Exactly one gnt per cycle; no gnt outside IDLE.
  - Request fields are captured into an internal transaction register at grant.
- FSM:
  - IDLE --grant load--> RD_WAIT (ram_r_ena=1 at T).
  - IDLE --grant WORD store--> RESP (ram_w_ena=1, ram_wdata=d_wdata at T).
  - IDLE --grant sub-word store--> RMW_RD (ram_r_ena=1 at T).
  - RD_WAIT: extract lane, extend, register into i_rdata/d_rdata -> RESP.
  - RMW_RD: merge the store bytes into ram_rdata; ram_w_ena=1 and ram_wdata=merged this same cycle (T+1) -> RESP.
  - RESP: valid pulse for the owning port -> IDLE.
- Latency, measured from the gnt cycle T:
  - load: valid at T+2.
  - WORD store: valid at T+1.
  - sub-word store: valid at T+2.
  - misaligned access: valid at T+1.
- Throughput: a new grant is possible the cycle after RESP.
- ram_addr is held from grant through the final RAM cycle.
- Extension: HALF_S/BYTE_S sign-extend from the top bit of the lane; _U variants zero-extend.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all enables drop asynchronously.
  - Any transaction in RMW_RD is abandoned with no RAM write.
  - No response is issued for the dropped transaction.

Decomposition:
- Shared package/defines.vh holds:
  - type codes and TYPE_W (EXT_MEM_CWIDTH).
  - FSM state encodings.
  - port ID constants PORT_I / PORT_D.
- One natural sub-module: mem_lane_unit (combinational).
  - Inputs: word, pos, type, store data.
  - Outputs: extended load value, merged store word, misaligned flag.
  - Reused for load extraction and the RMW merge.

Test Plan:
- Fetch word: RAM[4]=0xDEADBEEF; i_req, i_addr=0x10 -> i_gnt at T, ram_r_ena with ram_addr=4 at T, i_valid with i_rdata=0xDEADBEEF at T+2.
- Round-robin: i_req and d_req held high together for 4 grants after reset -> grant order I, D, I, D; never both gnt in one cycle.
- Byte RMW store: RAM[1]=0x11223344; store BYTE_U d_addr=0x6 d_wdata=0xAB -> ram_r_ena at T, ram_w_ena with ram_wdata=0x11AB3344 at T+1, d_valid at T+2.
- Signed half load: RAM[2]=0x8001_7FFF; HALF_S at 0xA -> d_rdata=0xFFFF8001; HALF_U at 0x8 -> 0x00007FFF.
- Misaligned: WORD load at 0x2 -> d_valid=d_err=1 at T+1; no ram_r_ena/ram_w_ena; d_rdata unchanged.
- Reset mid-RMW: assert rst=0 in RMW_RD -> no ram_w_ena ever asserted; RAM word unchanged; outputs zero; first grant after release goes to port I.
